oneapi_avs_to_axs_pixel_buffer: RTL
===================================

# oneapi_avs_to_axs_pixel_buffer

Return-path stage that takes pixel beats from a oneAPI kernel's Avalon Streaming source and presents them on an Intel Streaming Video AXI4-Stream transmitter. It sits directly downstream of the kernel and mirrors the input-side AXI4-S-to-Avalon gasket. It strips per-channel padding and maps start/end-of-packet to TUSER[0]/TLAST. A small show-ahead FIFO decouples the kernel from downstream backpressure, and an optional line-length checker runs at the input.

## Interface
- PARALLEL_PIXELS, 1, pixels per beat
- BITS_PER_CHANNEL, 8, significant bits per color channel
- CHANNELS, 3, channels per pixel
- BITS_PER_CHANNEL_AV, 8, padded channel width on the Avalon side
- BITS_PER_PIXEL_AV, 24, padded pixel width on the Avalon side
- BITS_AV, 24, Avalon data width
- EMPTY_BITS, 2, width of asi_empty
- BITS_PER_CHANNEL_AXI, 8, channel width on the AXI side
- BITS_PER_PIXEL_AXI, 24, pixel width on the AXI side
- BITS_AXI, 24, width of axm_tdata
- TUSER_BITS, 3, width of axm_tuser
- FIFO_DEPTH, 4, FIFO entries; power of two, ≥2
- LINE_BEATS, 1920, expected beats per line (checker only)

Ports:
- csi_clk  in  1  clock
- rsi_reset  in  1  asynchronous, active-high reset
- asi_ready  out  1  sink ready (readyLatency 0)
- asi_valid  in  1  sink valid
- asi_data  in  BITS_AV  padded pixel data
- asi_startofpacket  in  1  first beat of frame
- asi_endofpacket  in  1  last beat of line
- asi_empty  in  EMPTY_BITS  ignored
- axm_tready  in  1  downstream ready
- axm_tvalid  out  1  transmitter valid
- axm_tdata  out  BITS_AXI  packed pixel data
- axm_tlast  out  1  end of line
- axm_tuser  out  TUSER_BITS  [0]=start of frame; other bits 0
- line_err  out  1  sticky line-length error (0 when checker compiled out)

## Operation
- Accept: a beat is accepted when asi_valid && asi_ready. asi_ready = (count < FIFO_DEPTH), derived from registered count only; no dependence on axm_tready.
- Remap: for each pixel p and channel c, AXI bits [p*BITS_PER_PIXEL_AXI + c*BITS_PER_CHANNEL_AXI +: BITS_PER_CHANNEL] take AV bits [p*BITS_PER_PIXEL_AV + c*BITS_PER_CHANNEL_AV +: BITS_PER_CHANNEL]. Padding is dropped. All other tdata bits are 0.
- FIFO entry: {remapped data, sop, tlast_final}. The FIFO uses read/write pointers of clog2(FIFO_DEPTH) bits that wrap naturally, plus a count from 0 to FIFO_DEPTH.
- Output: axm_tvalid = (count != 0). Data, tlast and tuser come combinationally from the head entry. The head pops when axm_tvalid && axm_tready.
- Simultaneous push and pop: count is unchanged and the pointers advance. A full FIFO with a pop in the same cycle still deasserts asi_ready that cycle.
- Downstream stall: with axm_tvalid high, tdata/tlast/tuser hold stable until accepted.

## Timing
- Reset values: asi_ready=1, axm_tvalid=0, axm_tdata=0 (empty FIFO head is don't-care but driven 0), axm_tlast=0, axm_tuser=0, line_err=0. The pointers, count and line counter are all 0.
- Reset mid-operation clears all FIFO contents immediately; in-flight beats are lost.
- Latency: a beat accepted at edge N is visible on axm_* after edge N (one cycle). There is no bypass path.
- Throughput: one beat per cycle sustained while axm_tready=1.

## Configuration
- ONEAPI_GASKET_LINE_CHECK_EN defined:
  - A line counter (clog2(LINE_BEATS) bits) counts accepted beats.
  - On an accepted beat with sop while the counter is nonzero: set line_err; the beat counts as the first beat of the new line.
  - On eop with counter != LINE_BEATS-1: set line_err; tlast_final=1; counter→0.
  - On counter == LINE_BEATS-1 without eop: force tlast_final=1; set line_err; counter→0.
  - Correct eop: tlast_final=1; counter→0.
  - line_err stays set until reset.
- Macro undefined: tlast_final = asi_endofpacket; no counter; line_err tied 0.

## Test plan
- Reset, then 4 beats with data 0x112233..0x445566, axm_tready=1 → each appears one cycle later, unchanged (8-bit defaults); tuser[0]=1 on beat 0 only.
- BITS_PER_CHANNEL_AV=16, BITS_PER_CHANNEL=10, asi_data=0xFFFF_FFFF_FFFF → axm_tdata channels each 0x3FF (upper padding removed).
- axm_tready=0, stream 6 beats → asi_ready drops after 4 accepts; release tready → all 4 emitted in order, then the remaining 2; no loss or duplication.
- Checker on, LINE_BEATS=4: eop on beat 2 → tlast on beat 2, line_err=1. Separately, no eop for 4 beats → tlast forced on beat 4, line_err=1.
- Assert rsi_reset with 3 beats buffered → axm_tvalid=0 and asi_ready=1 asynchronously; after release, the FIFO is empty and line_err=0.

Source files
------------

// File: rtl/oneapi_avs_to_axs_pixel_buffer.sv
// Avalon-ST pixel source to AXI4-Stream video transmitter: channel de-padding, SOP/EOP mapping, show-ahead FIFO.
// Optional input line-length checker enabled by defining ONEAPI_GASKET_LINE_CHECK_EN.
module oneapi_avs_to_axs_pixel_buffer #(
   parameter int PARALLEL_PIXELS      = 1,
   parameter int BITS_PER_CHANNEL     = 8,
   parameter int CHANNELS             = 3,
   parameter int BITS_PER_CHANNEL_AV  = 8,
   parameter int BITS_PER_PIXEL_AV    = 24,
   parameter int BITS_AV              = 24,
   parameter int EMPTY_BITS           = 2,
   parameter int BITS_PER_CHANNEL_AXI = 8,
   parameter int BITS_PER_PIXEL_AXI   = 24,
   parameter int BITS_AXI             = 24,
   parameter int TUSER_BITS           = 3,
   parameter int FIFO_DEPTH           = 4,
   parameter int LINE_BEATS           = 1920
) (
   input  logic                  csi_clk,
   input  logic                  rsi_reset,
   output logic                  asi_ready,
   input  logic                  asi_valid,
   input  logic [BITS_AV-1:0]    asi_data,
   input  logic                  asi_startofpacket,
   input  logic                  asi_endofpacket,
   input  logic [EMPTY_BITS-1:0] asi_empty,
   input  logic                  axm_tready,
   output logic                  axm_tvalid,
   output logic [BITS_AXI-1:0]   axm_tdata,
   output logic                  axm_tlast,
   output logic [TUSER_BITS-1:0] axm_tuser,
   output logic                  line_err
);
   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

   typedef struct packed {
      logic [BITS_AXI-1:0] data;
      logic                sop;
      logic                last;
   } entry_t;

   entry_t              mem [FIFO_DEPTH];
   entry_t              head;
   logic [PTR_W-1:0]    wr_ptr, rd_ptr;
   logic [CNT_W-1:0]    count;
   logic [BITS_AXI-1:0] remap;
   logic                tlast_final, push, pop;

   // Padding bits are dropped by design; empty carries no information for full-pixel beats.
   logic unused_inputs;
   assign unused_inputs = ^{asi_empty, asi_data};

   always_comb begin
      remap = '0;
      for (int p = 0; p < PARALLEL_PIXELS; p++)
         for (int c = 0; c < CHANNELS; c++)
            remap[p*BITS_PER_PIXEL_AXI + c*BITS_PER_CHANNEL_AXI +: BITS_PER_CHANNEL] =
               asi_data[p*BITS_PER_PIXEL_AV + c*BITS_PER_CHANNEL_AV +: BITS_PER_CHANNEL];
   end

   // Ready looks only at registered occupancy, so a full FIFO stalls even when popping.
   assign asi_ready  = (count < DEPTH_C);
   assign axm_tvalid = (count != '0);
   assign push       = asi_valid && asi_ready;
   assign pop        = axm_tvalid && axm_tready;

   always_ff @(posedge csi_clk or posedge rsi_reset) begin
      if (rsi_reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         if (push && !pop)      count <= count + 1'b1;
         else if (pop && !push) count <= count - 1'b1;
      end
   end

   always_ff @(posedge csi_clk) begin
      if (push) mem[wr_ptr] <= '{data: remap, sop: asi_startofpacket, last: tlast_final};
   end

   assign head      = axm_tvalid ? mem[rd_ptr] : '0;
   assign axm_tdata = head.data;
   assign axm_tlast = head.last;
   assign axm_tuser = TUSER_BITS'(head.sop);

`ifdef ONEAPI_GASKET_LINE_CHECK_EN
   localparam int LC_W = (LINE_BEATS > 1) ? $clog2(LINE_BEATS) : 1;
   localparam logic [LC_W-1:0] LAST_BEAT = LC_W'(LINE_BEATS - 1);

   logic [LC_W-1:0] line_cnt, eff_cnt, line_cnt_nxt;
   logic            err_set;

   // A SOP always restarts the line; a mid-line SOP is itself an error.
   always_comb begin
      eff_cnt      = asi_startofpacket ? '0 : line_cnt;
      err_set      = asi_startofpacket && (line_cnt != '0);
      tlast_final  = 1'b0;
      line_cnt_nxt = eff_cnt + 1'b1;
      if (asi_endofpacket) begin
         tlast_final  = 1'b1;
         line_cnt_nxt = '0;
         if (eff_cnt != LAST_BEAT) err_set = 1'b1;
      end else if (eff_cnt == LAST_BEAT) begin
         tlast_final  = 1'b1;
         line_cnt_nxt = '0;
         err_set      = 1'b1;
      end
   end

   always_ff @(posedge csi_clk or posedge rsi_reset) begin
      if (rsi_reset) begin
         line_cnt <= '0;
         line_err <= 1'b0;
      end else if (push) begin
         line_cnt <= line_cnt_nxt;
         if (err_set) line_err <= 1'b1;
      end
   end
`else
   assign tlast_final = asi_endofpacket;
   assign line_err    = 1'b0;
`endif

endmodule
